mem_handshake_ram: RTL and testbench

MEM_HANDSHAKE_RAM -- requirements
Module: mem_handshake_ram

---
 rtl/mem_handshake_ram.sv | 163 ++++++++++++++++
 tb/tb_mem_handshake_ram.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_handshake_ram.sv
// Byte-addressed big-endian RAM behind an MFA/MOC request-complete handshake,
// with a programmable number of wait states before each access completes.
module mem_handshake_ram #(
    parameter int unsigned AW          = 8,
    parameter int unsigned WAIT_STATES = 2,
    parameter bit          ALIGN_CHK   = 1'b1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          MFA,
    input  logic          ReadWrite,
    input  logic [AW-1:0] Address,
    input  logic [31:0]   DataIn,
    input  logic [1:0]    dSize,
    input  logic          SignExt,
    output logic [31:0]   DataOut,
    output logic          MOC,
    output logic          Err
);

    localparam int unsigned Depth = 2 ** AW;
    localparam int unsigned CW    = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [1:0]      size_q, size_d;
    logic            rw_q, rw_d;
    logic            sext_q, sext_d;
    logic            moc_q, moc_d;
    logic            err_q, err_d;
    logic [31:0]     dout_q, dout_d;

    logic [7:0]      mem [Depth];
    logic [AW-1:0]   a0, a1, a2, a3;
    logic            misalign, acc_err, we;
    logic [31:0]     rdata;

    // Trailing byte addresses wrap naturally in AW bits.
    assign a0 = addr_q;
    assign a1 = addr_q + AW'(1);
    assign a2 = addr_q + AW'(2);
    assign a3 = addr_q + AW'(3);

    assign misalign = ALIGN_CHK &&
                      (((size_q == 2'b01) && addr_q[0]) ||
                       ((size_q == 2'b10) && (addr_q[1:0] != 2'b00)));
    assign acc_err  = (size_q == 2'b11) || misalign;

    always_comb begin
        rdata = '0;
        case (size_q)
            2'b00:   rdata = {{24{sext_q & mem[a0][7]}}, mem[a0]};
            2'b01:   rdata = {{16{sext_q & mem[a0][7]}}, mem[a0], mem[a1]};
            2'b10:   rdata = {mem[a0], mem[a1], mem[a2], mem[a3]};
            default: rdata = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        size_d  = size_q;
        rw_d    = rw_q;
        sext_d  = sext_q;
        moc_d   = moc_q;
        err_d   = err_q;
        dout_d  = dout_q;
        we      = 1'b0;
        case (state_q)
            StIdle: begin
                if (MFA) begin
                    addr_d  = Address;
                    wdata_d = DataIn;
                    size_d  = dSize;
                    rw_d    = ReadWrite;
                    sext_d  = SignExt;
                    cnt_d   = CW'(WAIT_STATES);
                    state_d = StBusy;
                end
            end
            StBusy: begin
                if (!MFA) begin
                    state_d = StIdle;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    state_d = StDone;
                    moc_d   = 1'b1;
                    err_d   = acc_err;
                    dout_d  = (!acc_err && rw_q) ? rdata : 32'h0;
                    // Reset at this same edge must suppress the store.
                    we      = !acc_err && !rw_q && reset_n;
                end
            end
            StDone: begin
                if (!MFA) begin
                    moc_d   = 1'b0;
                    err_d   = 1'b0;
                    dout_d  = 32'h0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            size_q  <= '0;
            rw_q    <= 1'b0;
            sext_q  <= 1'b0;
            moc_q   <= 1'b0;
            err_q   <= 1'b0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            size_q  <= size_d;
            rw_q    <= rw_d;
            sext_q  <= sext_d;
            moc_q   <= moc_d;
            err_q   <= err_d;
            dout_q  <= dout_d;
        end
    end

    // Array is deliberately left out of reset so contents survive it.
    always_ff @(posedge clk) begin
        if (we) begin
            case (size_q)
                2'b00: mem[a0] <= wdata_q[7:0];
                2'b01: begin
                    mem[a0] <= wdata_q[15:8];
                    mem[a1] <= wdata_q[7:0];
                end
                2'b10: begin
                    mem[a0] <= wdata_q[31:24];
                    mem[a1] <= wdata_q[23:16];
                    mem[a2] <= wdata_q[15:8];
                    mem[a3] <= wdata_q[7:0];
                end
                default: ;
            endcase
        end
    end

    assign DataOut = dout_q;
    assign MOC     = moc_q;
    assign Err     = err_q;

endmodule

// File: tb/tb_mem_handshake_ram.sv
// Bench for mem_handshake_ram: two instances (2 wait states + alignment check,
// 0 wait states + address wrap) driven with directed and random requests.
module tb_mem_handshake_ram;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n  [2];
    logic        mfa    [2];
    logic        rw_s   [2];
    logic [7:0]  addr_s [2];
    logic [31:0] din_s  [2];
    logic [1:0]  sz_s   [2];
    logic        sx_s   [2];
    logic [31:0] dout   [2];
    logic        moc    [2];
    logic        err    [2];

    logic [7:0]  model [2][256];
    int          n_tests = 0;
    int          n_fail  = 0;

    mem_handshake_ram #(.AW(8), .WAIT_STATES(2), .ALIGN_CHK(1'b1)) dut_a (
        .clk(clk), .reset_n(rst_n[0]), .MFA(mfa[0]), .ReadWrite(rw_s[0]),
        .Address(addr_s[0]), .DataIn(din_s[0]), .dSize(sz_s[0]), .SignExt(sx_s[0]),
        .DataOut(dout[0]), .MOC(moc[0]), .Err(err[0])
    );

    mem_handshake_ram #(.AW(8), .WAIT_STATES(0), .ALIGN_CHK(1'b0)) dut_b (
        .clk(clk), .reset_n(rst_n[1]), .MFA(mfa[1]), .ReadWrite(rw_s[1]),
        .Address(addr_s[1]), .DataIn(din_s[1]), .dSize(sz_s[1]), .SignExt(sx_s[1]),
        .DataOut(dout[1]), .MOC(moc[1]), .Err(err[1])
    );

    function automatic int lat_of(input int d);
        return (d == 0) ? 2 : 0;
    endfunction

    function automatic logic [7:0] mem_rd(input int d, input logic [7:0] a);
        if (d == 0) return dut_a.mem[a];
        return dut_b.mem[a];
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // One full request/complete/release transaction with latency and hold checks.
    task automatic do_op(input int d, input bit rw, input logic [7:0] a, input logic [31:0] wd,
                         input logic [1:0] sz, input bit sx,
                         output logic [31:0] got_do, output logic got_err);
        int          nb;
        bit          exp_err;
        logic [31:0] exp_do;
        logic [7:0]  ai;
        nb      = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        exp_err = (sz == 2'b11) ||
                  ((d == 0) && (((sz == 2'b01) && a[0]) || ((sz == 2'b10) && (a[1:0] != 2'b00))));
        exp_do  = 32'h0;
        if (!exp_err) begin
            for (int i = 0; i < nb; i++) begin
                ai = a + 8'(i);
                if (rw) exp_do = (exp_do << 8) | 32'(model[d][ai]);
                else    model[d][ai] = 8'(wd >> (8 * (nb - 1 - i)));
            end
            if (rw && sx && (nb == 1) && exp_do[7])  exp_do = exp_do | 32'hFFFF_FF00;
            if (rw && sx && (nb == 2) && exp_do[15]) exp_do = exp_do | 32'hFFFF_0000;
        end
        got_do  = 32'h0;
        got_err = 1'b0;

        @(negedge clk);
        mfa[d] = 1'b1; rw_s[d] = rw; addr_s[d] = a; din_s[d] = wd; sz_s[d] = sz; sx_s[d] = sx;
        @(posedge clk);
        #1;
        rw_s[d] = 1'($urandom); addr_s[d] = 8'($urandom); din_s[d] = $urandom;
        sz_s[d] = 2'($urandom); sx_s[d] = 1'($urandom);
        for (int k = 0; k <= lat_of(d) + 1; k++) begin
            @(negedge clk);
            check_eq("moc_latency", 32'(moc[d]), 32'(k == lat_of(d) + 1));
        end
        got_do  = dout[d];
        got_err = err[d];
        check_eq("dataout", got_do, exp_do);
        check_eq("err", 32'(got_err), 32'(exp_err));
        @(negedge clk);
        check_eq("moc_hold", 32'(moc[d]), 32'd1);
        check_eq("dataout_hold", dout[d], exp_do);
        mfa[d] = 1'b0;
        @(negedge clk);
        check_eq("moc_clear", 32'(moc[d]), 32'd0);
        check_eq("out_clear", dout[d] | 32'(err[d]), 32'd0);
        if (!rw) begin
            for (int i = 0; i < 4; i++) begin
                ai = a + 8'(i);
                check_eq("mem_after_write", 32'(mem_rd(d, ai)), 32'(model[d][ai]));
            end
        end
    endtask

    // Word write cancelled in BUSY, either by dropping MFA or by reset.
    task automatic abort_op(input int d, input logic [7:0] a, input bit use_rst);
        logic [7:0] ai;
        @(negedge clk);
        mfa[d] = 1'b1; rw_s[d] = 1'b0; addr_s[d] = a; din_s[d] = $urandom | 32'h0101_0101;
        sz_s[d] = 2'b10;
        @(posedge clk);
        #1;
        if (use_rst) rst_n[d] = 1'b0;
        else         mfa[d]   = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check_eq(use_rst ? "moc_reset_abort" : "moc_mfa_abort", 32'(moc[d]), 32'd0);
        end
        mfa[d] = 1'b0;
        @(negedge clk);
        rst_n[d] = 1'b1;
        check_eq("abort_outputs", dout[d] | 32'(err[d]), 32'd0);
        for (int i = 0; i < 4; i++) begin
            ai = a + 8'(i);
            check_eq("mem_after_abort", 32'(mem_rd(d, ai)), 32'(model[d][ai]));
        end
    endtask

    logic [31:0] r_do;
    logic        r_err;

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst_n[d] = 1'b0; mfa[d] = 1'b0; rw_s[d] = 1'b0; addr_s[d] = '0;
            din_s[d] = '0; sz_s[d] = '0; sx_s[d] = 1'b0;
        end
        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check_eq("reset_moc", 32'(moc[d]), 32'd0);
            check_eq("reset_err", 32'(err[d]), 32'd0);
            check_eq("reset_dataout", dout[d], 32'd0);
        end
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;

        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 64; i++)
                do_op(d, 1'b0, 8'(i * 4), $urandom, 2'b10, 1'b0, r_do, r_err);

        do_op(0, 1'b0, 8'h04, 32'hCAFE_BABE, 2'b10, 1'b0, r_do, r_err);
        check_eq("word_write_dout", r_do, 32'h0);
        check_eq("mem4", 32'(mem_rd(0, 8'h04)), 32'hCA);
        check_eq("mem7", 32'(mem_rd(0, 8'h07)), 32'hBE);
        do_op(0, 1'b1, 8'h04, 32'h0, 2'b10, 1'b0, r_do, r_err);
        check_eq("word_read", r_do, 32'hCAFE_BABE);

        do_op(0, 1'b0, 8'h08, 32'hFFFF_FF80, 2'b00, 1'b0, r_do, r_err);
        do_op(0, 1'b0, 8'h09, 32'h0000_0001, 2'b00, 1'b0, r_do, r_err);
        do_op(0, 1'b1, 8'h08, 32'h0, 2'b01, 1'b1, r_do, r_err);
        check_eq("half_sext", r_do, 32'hFFFF_8001);
        do_op(0, 1'b1, 8'h08, 32'h0, 2'b01, 1'b0, r_do, r_err);
        check_eq("half_zext", r_do, 32'h0000_8001);
        do_op(0, 1'b1, 8'h08, 32'h0, 2'b00, 1'b1, r_do, r_err);
        check_eq("byte_sext", r_do, 32'hFFFF_FF80);

        do_op(0, 1'b0, 8'h06, 32'h1234_5678, 2'b10, 1'b0, r_do, r_err);
        check_eq("misaligned_err", 32'(r_err), 32'd1);
        do_op(0, 1'b0, 8'h10, 32'h1234_5678, 2'b11, 1'b0, r_do, r_err);
        check_eq("illegal_size_err", 32'(r_err), 32'd1);

        do_op(1, 1'b0, 8'hFE, 32'h1122_3344, 2'b10, 1'b0, r_do, r_err);
        check_eq("wrap_err", 32'(r_err), 32'd0);
        check_eq("wrap_fe", 32'(mem_rd(1, 8'hFE)), 32'h11);
        check_eq("wrap_ff", 32'(mem_rd(1, 8'hFF)), 32'h22);
        check_eq("wrap_00", 32'(mem_rd(1, 8'h00)), 32'h33);
        check_eq("wrap_01", 32'(mem_rd(1, 8'h01)), 32'h44);

        abort_op(0, 8'h20, 1'b0);
        abort_op(0, 8'h24, 1'b1);
        abort_op(1, 8'h30, 1'b0);
        abort_op(1, 8'h34, 1'b1);
        do_op(0, 1'b1, 8'h24, 32'h0, 2'b10, 1'b0, r_do, r_err);
        do_op(1, 1'b1, 8'h34, 32'h0, 2'b10, 1'b0, r_do, r_err);

        for (int n = 0; n < 300; n++) begin
            int          d;
            int          r;
            logic [1:0]  sz;
            logic [7:0]  a;
            d  = n % 2;
            r  = $urandom_range(0, 7);
            sz = (r < 2) ? 2'b00 : (r < 4) ? 2'b01 : (r < 7) ? 2'b10 : 2'b11;
            a  = 8'($urandom);
            if ($urandom_range(0, 1) == 1) a = a & ((sz == 2'b01) ? 8'hFE : 8'hFC);
            do_op(d, 1'($urandom), a, $urandom, sz, 1'($urandom), r_do, r_err);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
